// File: rtl/imac_d4.sv
// Inverse Daubechies-4 synthesis MAC: {a,d} coefficient pairs in, reconstructed 8-bit pixel pairs out.
// Optional sticky saturation flag (port o_saturated) when IMAC_D4_SAT_FLAG_EN is defined.
module imac_d4 #(
    parameter int unsigned WIDTH     = 256,
    parameter int unsigned HEIGHT    = 256,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned COEF_FRAC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*COEF_W-1:0]      coef_input,
    input  logic                     i_valid,
    input  logic                     last_coef,
    input  logic [$clog2(WIDTH)-1:0] i_row_column_pointer,
    input  logic [$clog2(WIDTH)-1:0] i_pixel_pointer,
    output logic                     o_ready,
    output logic [15:0]              pixel_output,
    output logic                     o_valid,
    output logic [$clog2(WIDTH)-1:0] o_row_column_pointer,
    output logic [$clog2(WIDTH)-1:0] o_pixel_pointer
`ifdef IMAC_D4_SAT_FLAG_EN
    ,
    output logic                     o_saturated
`endif
);

    localparam int unsigned PTR_W  = $clog2(WIDTH);
    localparam int unsigned H_W    = 16;
    localparam int unsigned SUM_W  = 32;
    localparam int unsigned FRAC_W = COEF_FRAC + 14;

    // Synthesis filter taps, Q2.14
    localparam logic signed [H_W-1:0] H0 = 16'sd7913;
    localparam logic signed [H_W-1:0] H1 = 16'sd13705;
    localparam logic signed [H_W-1:0] H2 = 16'sd3672;
    localparam logic signed [H_W-1:0] H3 = -16'sd2120;

    localparam logic signed [SUM_W-1:0] RND     = SUM_W'(64'd1 << (FRAC_W - 1));
    localparam logic signed [SUM_W-1:0] PIX_MAX = 32'sd255;

    if (WIDTH < 4 || HEIGHT < 1) begin : g_cfg_check
        $error("imac_d4: WIDTH must be >= 4 and HEIGHT >= 1");
    end

    typedef struct packed {
        logic signed [COEF_W-1:0] a;
        logic signed [COEF_W-1:0] d;
    } pair_t;

    typedef enum logic {
        ST_RUN,
        ST_WRAP
    } state_e;

    function automatic logic signed [SUM_W-1:0] mul(input logic signed [COEF_W-1:0] c,
                                                    input logic signed [H_W-1:0]    h);
        return SUM_W'(c) * SUM_W'(h);
    endfunction

    function automatic logic [7:0] sat8(input logic signed [SUM_W-1:0] v);
        if (v < 0) begin
            return 8'h00;
        end else if (v > PIX_MAX) begin
            return 8'hFF;
        end
        return v[7:0];
    endfunction

    pair_t            in_c;
    logic             first_c;

    state_e           state_q, state_d;
    pair_t            first_q, first_d;
    pair_t            prev_q, prev_d;
    logic [PTR_W-1:0] last_row_q, last_row_d;
    logic             line_act_q, line_act_d;

    logic             s0_vld_q, s0_vld_d;
    pair_t            s0_p_q, s0_p_d;
    pair_t            s0_c_q, s0_c_d;
    logic [PTR_W-1:0] s0_row_q, s0_row_d;
    logic [PTR_W-1:0] s0_pix_q, s0_pix_d;

    logic signed [SUM_W-1:0] prod_c [8];
    logic                    s1_vld_q;
    logic signed [SUM_W-1:0] s1_prod_q [8];
    logic [PTR_W-1:0]        s1_row_q, s1_pix_q;

    logic                    s2_vld_q;
    logic signed [SUM_W-1:0] s2_even_q, s2_odd_q;
    logic [PTR_W-1:0]        s2_row_q, s2_pix_q;

    logic signed [SUM_W-1:0] sh_e_c, sh_o_c;

    logic                    o_valid_q;
    logic [15:0]             pixel_q;
    logic [PTR_W-1:0]        o_row_q, o_pix_q;

    assign in_c    = pair_t'(coef_input);
    assign first_c = (i_pixel_pointer == '0);
    assign o_ready = (state_q == ST_RUN);

    // Pair sequencing: n=0 seeds first/prev, n>=1 issues (prev,cur), WRAP issues (last,first)
    always_comb begin : fsm_comb
        state_d    = state_q;
        first_d    = first_q;
        prev_d     = prev_q;
        last_row_d = last_row_q;
        line_act_d = line_act_q;
        s0_vld_d   = 1'b0;
        s0_p_d     = s0_p_q;
        s0_c_d     = s0_c_q;
        s0_row_d   = s0_row_q;
        s0_pix_d   = s0_pix_q;
        case (state_q)
            ST_RUN: begin
                if (i_valid) begin
                    if (first_c) begin
                        first_d    = in_c;
                        prev_d     = in_c;
                        last_row_d = i_row_column_pointer;
                        line_act_d = 1'b1;
                    end else if (line_act_q) begin
                        s0_vld_d   = 1'b1;
                        s0_p_d     = prev_q;
                        s0_c_d     = in_c;
                        s0_row_d   = i_row_column_pointer;
                        s0_pix_d   = i_pixel_pointer;
                        prev_d     = in_c;
                        last_row_d = i_row_column_pointer;
                        if (last_coef) begin
                            line_act_d = 1'b0;
                            state_d    = ST_WRAP;
                        end
                    end
                end
            end
            ST_WRAP: begin
                s0_vld_d = 1'b1;
                s0_p_d   = prev_q;
                s0_c_d   = first_q;
                s0_row_d = last_row_q;
                s0_pix_d = '0;
                state_d  = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : ctrl_ff
        if (!rst_n) begin
            state_q    <= ST_RUN;
            first_q    <= '0;
            prev_q     <= '0;
            last_row_q <= '0;
            line_act_q <= 1'b0;
            s0_vld_q   <= 1'b0;
            s0_p_q     <= '0;
            s0_c_q     <= '0;
            s0_row_q   <= '0;
            s0_pix_q   <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            prev_q     <= prev_d;
            last_row_q <= last_row_d;
            line_act_q <= line_act_d;
            s0_vld_q   <= s0_vld_d;
            s0_p_q     <= s0_p_d;
            s0_c_q     <= s0_c_d;
            s0_row_q   <= s0_row_d;
            s0_pix_q   <= s0_pix_d;
        end
    end

    // Products 0..3 feed the even pixel, 4..7 the odd pixel
    always_comb begin : prod_comb
        prod_c[0] = mul(s0_p_q.a, H2);
        prod_c[1] = mul(s0_p_q.d, H1);
        prod_c[2] = mul(s0_c_q.a, H0);
        prod_c[3] = mul(s0_c_q.d, H3);
        prod_c[4] = mul(s0_p_q.a, H3);
        prod_c[5] = mul(s0_p_q.d, H0);
        prod_c[6] = mul(s0_c_q.a, H1);
        prod_c[7] = mul(s0_c_q.d, H2);
    end

    always_ff @(posedge clk or negedge rst_n) begin : mul_ff
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_row_q <= '0;
            s1_pix_q <= '0;
            for (int i = 0; i < 8; i++) begin
                s1_prod_q[i] <= '0;
            end
        end else begin
            s1_vld_q <= s0_vld_q;
            if (s0_vld_q) begin
                s1_prod_q <= prod_c;
                s1_row_q  <= s0_row_q;
                s1_pix_q  <= s0_pix_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : sum_ff
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_even_q <= '0;
            s2_odd_q  <= '0;
            s2_row_q  <= '0;
            s2_pix_q  <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_even_q <= s1_prod_q[0] + s1_prod_q[1] + s1_prod_q[2] + s1_prod_q[3];
                s2_odd_q  <= s1_prod_q[4] - s1_prod_q[5] + s1_prod_q[6] - s1_prod_q[7];
                s2_row_q  <= s1_row_q;
                s2_pix_q  <= s1_pix_q;
            end
        end
    end

    // Round half-up then drop the fractional bits
    assign sh_e_c = (s2_even_q + RND) >>> FRAC_W;
    assign sh_o_c = (s2_odd_q + RND) >>> FRAC_W;

    always_ff @(posedge clk or negedge rst_n) begin : out_ff
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            pixel_q   <= '0;
            o_row_q   <= '0;
            o_pix_q   <= '0;
        end else begin
            o_valid_q <= s2_vld_q;
            if (s2_vld_q) begin
                pixel_q <= {sat8(sh_e_c), sat8(sh_o_c)};
                o_row_q <= s2_row_q;
                o_pix_q <= s2_pix_q;
            end
        end
    end

    assign o_valid              = o_valid_q;
    assign pixel_output         = pixel_q;
    assign o_row_column_pointer = o_row_q;
    assign o_pixel_pointer      = o_pix_q;

`ifdef IMAC_D4_SAT_FLAG_EN
    logic sat_q;
    logic sat_clr_c;
    logic clamp_c;

    assign sat_clr_c = i_valid && (state_q == ST_RUN) && first_c;
    assign clamp_c   = s2_vld_q && ((sh_e_c < 0) || (sh_e_c > PIX_MAX) ||
                                    (sh_o_c < 0) || (sh_o_c > PIX_MAX));

    // A clamp landing in the same cycle as a new line start still sets the flag
    always_ff @(posedge clk or negedge rst_n) begin : sat_ff
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (clamp_c) begin
            sat_q <= 1'b1;
        end else if (sat_clr_c) begin
            sat_q <= 1'b0;
        end
    end

    assign o_saturated = sat_q;
`endif

endmodule

// File: tb/tb_imac_d4.sv
// Self-checking bench for imac_d4 (WIDTH=8): per-cycle vector table plus reset and round-trip sequences.
module tb_imac_d4;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NV    = 56;
    localparam int          H0    = 7913;
    localparam int          H1    = 13705;
    localparam int          H2    = 3672;
    localparam int          H3    = -2120;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] coef_input;
    logic        i_valid;
    logic        last_coef;
    logic [2:0]  i_row;
    logic [2:0]  i_pix;
    logic        o_ready;
    logic [15:0] pixel_output;
    logic        o_valid;
    logic [2:0]  o_row;
    logic [2:0]  o_pix;
`ifdef IMAC_D4_SAT_FLAG_EN
    logic        o_sat;
`endif

    imac_d4 #(.WIDTH(WIDTH), .HEIGHT(8), .COEF_W(16), .COEF_FRAC(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .coef_input           (coef_input),
        .i_valid              (i_valid),
        .last_coef            (last_coef),
        .i_row_column_pointer (i_row),
        .i_pixel_pointer      (i_pix),
        .o_ready              (o_ready),
        .pixel_output         (pixel_output),
        .o_valid              (o_valid),
        .o_row_column_pointer (o_row),
        .o_pixel_pointer      (o_pix)
`ifdef IMAC_D4_SAT_FLAG_EN
        ,
        .o_saturated          (o_sat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        last;
        logic [15:0] a;
        logic [15:0] d;
        logic [2:0]  row;
        logic [2:0]  pix;
        logic        exp_rdy;
        logic        exp_ov;
        logic [15:0] exp_px;
        logic [2:0]  exp_row;
        logic [2:0]  exp_pix;
    } vec_t;

    vec_t vec [NV];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [15:0] got_px  [$];
    logic [2:0]  got_pix [$];
    logic [2:0]  got_row [$];

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            got_px.push_back(pixel_output);
            got_pix.push_back(o_pix);
            got_row.push_back(o_row);
        end
    end

    task automatic put_in(input int c, input logic last, input int a, input int d,
                          input int row, input int pix);
        vec[c].vld  = 1'b1;
        vec[c].last = last;
        vec[c].a    = 16'(a);
        vec[c].d    = 16'(d);
        vec[c].row  = 3'(row);
        vec[c].pix  = 3'(pix);
    endtask

    task automatic put_out(input int c, input logic [15:0] px, input int row, input int pix);
        vec[c].exp_ov  = 1'b1;
        vec[c].exp_px  = px;
        vec[c].exp_row = 3'(row);
        vec[c].exp_pix = 3'(pix);
    endtask

    // Constant-coefficient line starting at cycle c0; outputs arrive m=1,2,3 then wrap m=0
    task automatic put_line(input int c0, input int row, input int a, input int d,
                            input logic [15:0] px);
        for (int n = 0; n < 4; n++) put_in(c0 + n, n == 3, a, d, row, n);
        vec[c0 + 4].exp_rdy = 1'b0;
        for (int k = 0; k < 4; k++) put_out(c0 + 5 + k, px, row, (k + 1) % 4);
    endtask

    task automatic drive(input logic v, input logic last, input int a, input int d,
                         input int row, input int pix);
        @(posedge clk);
        #1;
        i_valid    = v;
        last_coef  = last;
        coef_input = {16'(a), 16'(d)};
        i_row      = 3'(row);
        i_pix      = 3'(pix);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic chk_near(input string nm, input int got, input int want);
        n_vec++;
        if (got > want + 1 || got < want - 1) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d +/-1", nm, got, want);
        end
    endtask

    task automatic clear_got();
        got_px.delete();
        got_pix.delete();
        got_row.delete();
    endtask

    initial begin
        int x [8];
        int ca [4];
        int cd [4];
        logic ready_low;
        int   sa, sd, m;

        rst_n = 1'b0; i_valid = 1'b0; last_coef = 1'b0;
        coef_input = '0; i_row = '0; i_pix = '0;

        for (int c = 0; c < NV; c++) begin
            vec[c] = '{vld: 1'b0, last: 1'b0, a: '0, d: '0, row: '0, pix: '0,
                       exp_rdy: 1'b1, exp_ov: 1'b0, exp_px: '0, exp_row: '0, exp_pix: '0};
        end
        put_line(0, 3, 5770, 0, 16'hFFFF);
        put_line(10, 5, 0, 0, 16'h0000);
        put_line(20, 7, 32767, 0, 16'hFFFF);
        put_line(30, 1, -32768, 0, 16'h0000);
        put_in(34, 1'b0, 5770, 0, 2, 0);
        put_line(35, 2, 5770, 0, 16'hFFFF);
        put_in(45, 1'b0, 1600, 0, 4, 0);
        put_in(46, 1'b0, 1600, 800, 4, 1);
        put_in(47, 1'b0, 3200, -800, 4, 2);
        put_in(48, 1'b1, 1600, 1600, 4, 3);
        vec[49].exp_rdy = 1'b0;
        put_out(50, 16'h403C, 4, 1);
        put_out(51, 16'hA78D, 4, 2);
        put_out(52, 16'h263C, 4, 3);
        put_out(53, 16'h9A16, 4, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset o_valid", int'(o_valid), 0);
        chk("reset pixel_output", int'(pixel_output), 0);
        chk("reset o_row", int'(o_row), 0);
        chk("reset o_pix", int'(o_pix), 0);
        chk("reset o_ready", int'(o_ready), 1);
        rst_n = 1'b1;

        for (int c = 0; c < NV; c++) begin
            drive(vec[c].vld, vec[c].last, int'($signed(vec[c].a)), int'($signed(vec[c].d)),
                  int'(vec[c].row), int'(vec[c].pix));
            @(negedge clk);
            n_vec++;
            if (o_ready !== vec[c].exp_rdy || o_valid !== vec[c].exp_ov ||
                (vec[c].exp_ov && (pixel_output !== vec[c].exp_px ||
                                   o_row !== vec[c].exp_row || o_pix !== vec[c].exp_pix))) begin
                n_bad++;
                $display("FAIL vec %0d: ready=%0b valid=%0b px=%h row=%0d pix=%0d; want ready=%0b valid=%0b px=%h row=%0d pix=%0d",
                         c, o_ready, o_valid, pixel_output, o_row, o_pix, vec[c].exp_rdy,
                         vec[c].exp_ov, vec[c].exp_px, vec[c].exp_row, vec[c].exp_pix);
            end
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        repeat (6) @(posedge clk);

        // Reset in the middle of a line kills in-flight pairs
        clear_got();
        for (int n = 0; n < 3; n++) drive(1'b1, 1'b0, 5770, 0, 6, n);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset o_valid", int'(o_valid), 0);
        chk("midreset pixel_output", int'(pixel_output), 0);
        @(posedge clk);
        #1;
        chk("midreset o_valid next edge", int'(o_valid), 0);
        chk("midreset o_ready", int'(o_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 5770, 0, 6, 3);
        ready_low = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 0, 0, 0, 0);
            @(negedge clk);
            if (o_ready !== 1'b1) ready_low = 1'b1;
        end
        chk("orphan pair no stall", int'(ready_low), 0);
        chk("orphan pair no output", got_px.size(), 0);

        clear_got();
        for (int n = 0; n < 4; n++) drive(1'b1, n == 3, 5770, 0, 6, n);
        repeat (10) drive(1'b0, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post-reset line count", got_px.size(), 4);
        for (int k = 0; k < 4 && k < got_px.size(); k++) begin
            chk("post-reset px", int'(got_px[k]), 16'hFFFF);
            chk("post-reset pix order", int'(got_pix[k]), (k + 1) % 4);
            chk("post-reset row", int'(got_row[k]), 6);
        end

        // Round trip: ramp through the forward D4 analysis, coefficients scaled by 16
        for (int i = 0; i < 8; i++) x[i] = (i * 255) / 7;
        for (int k = 0; k < 4; k++) begin
            sa = H0 * x[2*k] + H1 * x[2*k+1] + H2 * x[(2*k+2) % 8] + H3 * x[(2*k+3) % 8];
            sd = H3 * x[2*k] - H2 * x[2*k+1] + H1 * x[(2*k+2) % 8] - H0 * x[(2*k+3) % 8];
            ca[k] = (sa + 512) >>> 10;
            cd[k] = (sd + 512) >>> 10;
        end
        clear_got();
        for (int n = 0; n < 4; n++) drive(1'b1, n == 3, ca[n], cd[n], 0, n);
        repeat (10) drive(1'b0, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        chk("ramp output count", got_px.size(), 4);
        for (int k = 0; k < 4 && k < got_px.size(); k++) begin
            m = int'(got_pix[k]);
            chk_near("ramp even", int'(got_px[k][15:8]), x[2*m]);
            chk_near("ramp odd", int'(got_px[k][7:0]), x[2*m+1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
